// File: rtl/ysyx_040066_icache_pkg.sv
// ysyx_040066_icache_pkg: shared state encoding and default geometry for the instruction cache
package ysyx_040066_icache_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FILL, ERR} state_t;
  localparam int SETS_DEF = 64;
  localparam int LINE_BEATS_DEF = 2;
  localparam int ADDR_W_DEF = 32;
  localparam int BEAT_W = 64;
  localparam int INSTR_W = 32;
endpackage

// File: rtl/ysyx_040066_icache_array.sv
// ysyx_040066_icache_array: valid/tag/data storage with async read, per-beat write and flash invalidate
module ysyx_040066_icache_array
  import ysyx_040066_icache_pkg::*;
#(
  parameter int SETS = SETS_DEF,
  parameter int LINE_BEATS = LINE_BEATS_DEF,
  parameter int TAG_W = 22,
  localparam int IDX_W = $clog2(SETS),
  localparam int CNT_W = LINE_BEATS > 1 ? $clog2(LINE_BEATS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic                         rd_valid,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [LINE_BEATS*BEAT_W-1:0] rd_line,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic                         beat_we,
  input  logic [CNT_W-1:0]             beat_sel,
  input  logic [BEAT_W-1:0]            beat_data,
  input  logic                         line_we,
  input  logic [TAG_W-1:0]             line_tag,
  input  logic                         inval
);
  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [BEAT_W-1:0] data [SETS][LINE_BEATS];
  always_ff @(posedge clk or negedge rst)
    if (!rst) valid <= '0;
    else if (inval) valid <= '0;
    else if (line_we) valid[wr_idx] <= 1'b1;
  always_ff @(posedge clk) begin
    if (beat_we) data[wr_idx][beat_sel] <= beat_data;
    if (line_we) tags[wr_idx] <= line_tag;
  end
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  for (genvar b = 0; b < LINE_BEATS; b++) begin : g_line
    assign rd_line[b*BEAT_W +: BEAT_W] = data[rd_idx][b];
  end
endmodule

// File: rtl/ysyx_040066_icache.sv
// ysyx_040066_icache: direct-mapped read-only instruction cache with burst refill and fence.i invalidate
module ysyx_040066_icache
  import ysyx_040066_icache_pkg::*;
#(
  parameter int SETS = SETS_DEF,
  parameter int LINE_BEATS = LINE_BEATS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        pc_rd,
  input  logic               instr_read,
  input  logic               fence_i,
  output logic [INSTR_W-1:0] instr_rd,
  output logic               instr_valid,
  output logic               instr_error,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ready,
  input  logic               mem_rvalid,
  input  logic [BEAT_W-1:0]  mem_rdata,
  input  logic               mem_rlast,
  input  logic               mem_rerror
);
  localparam int OFF_W = $clog2(8*LINE_BEATS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int CNT_W = LINE_BEATS > 1 ? $clog2(LINE_BEATS) : 1;
  state_t state, state_n;
  logic [ADDR_W-OFF_W-1:0] line_q;
  logic [CNT_W-1:0] cnt;
  logic err, fence_pend;
  logic rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [LINE_BEATS*BEAT_W-1:0] rd_line;
  logic fault, hit, beat, last, err_n, err_match, line_we;
  logic [INSTR_W-1:0] word;
  assign fault = (|pc_rd[1:0]) | (|pc_rd[63:ADDR_W]);
  assign hit = rd_valid && rd_tag == pc_rd[OFF_W+IDX_W +: TAG_W];
  assign word = rd_line[pc_rd[OFF_W-1:2]*INSTR_W +: INSTR_W];
  assign beat = state == FILL && mem_rvalid;
  assign last = beat && mem_rlast;
  assign err_n = err | mem_rerror;
  assign err_match = pc_rd[ADDR_W-1:OFF_W] == line_q && !(|pc_rd[63:ADDR_W]);
  // a fence arriving on the last beat must also keep the line invalid
  assign line_we = last && !err_n && !fence_pend && !fence_i;
  ysyx_040066_icache_array #(.SETS(SETS), .LINE_BEATS(LINE_BEATS), .TAG_W(TAG_W)) u_array (
    .clk(clk), .rst(rst), .rd_idx(pc_rd[OFF_W +: IDX_W]), .rd_valid(rd_valid), .rd_tag(rd_tag),
    .rd_line(rd_line), .wr_idx(line_q[IDX_W-1:0]), .beat_we(beat), .beat_sel(cnt),
    .beat_data(mem_rdata), .line_we(line_we), .line_tag(line_q[IDX_W +: TAG_W]), .inval(fence_i)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = instr_read && !fault && !hit ? REQ : IDLE;
      REQ:  state_n = mem_ready ? FILL : REQ;
      FILL: state_n = last ? (err_n ? ERR : IDLE) : FILL;
      ERR:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    mem_req = state == REQ;
    mem_addr = {line_q, {OFF_W{1'b0}}};
    instr_valid = (state == IDLE && instr_read && (fault || hit)) || (state == ERR && instr_read && err_match);
    instr_error = (state == IDLE && instr_read && fault) || (state == ERR && instr_read && err_match);
    instr_rd = state == IDLE && instr_read && !fault && hit ? word : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      line_q <= '0;
      cnt <= '0;
      err <= 1'b0;
      fence_pend <= 1'b0;
    end else begin
      if (state == IDLE && state_n == REQ) line_q <= pc_rd[ADDR_W-1:OFF_W];
      if (state == REQ && mem_ready) cnt <= '0;
      else if (beat) cnt <= cnt == CNT_W'(LINE_BEATS-1) ? '0 : cnt + 1'b1;
      if (state == REQ && mem_ready) err <= 1'b0;
      else if (beat && mem_rerror) err <= 1'b1;
      fence_pend <= state_n == IDLE ? 1'b0 : fence_pend | (fence_i && (state == REQ || state == FILL));
    end
endmodule

// File: tb/tb_ysyx_040066_icache.sv
// tb_ysyx_040066_icache: directed self-checking bench for the instruction cache
module tb_ysyx_040066_icache;
  logic clk = 0, rst = 0;
  logic [63:0] pc_rd = '0;
  logic instr_read = 0, fence_i = 0;
  logic [31:0] instr_rd;
  logic instr_valid, instr_error, mem_req;
  logic [31:0] mem_addr;
  logic mem_ready = 0, mem_rvalid = 0, mem_rlast = 0, mem_rerror = 0;
  logic [63:0] mem_rdata = '0;
  int n_chk = 0, n_pass = 0;
  localparam logic [63:0] B0 = 64'h00100093_00000013, B1 = 64'h00000073_00208133;
  localparam logic [63:0] C0 = 64'h22222222_11111111, C1 = 64'h44444444_33333333;
  ysyx_040066_icache dut (
    .clk(clk), .rst(rst), .pc_rd(pc_rd), .instr_read(instr_read), .fence_i(fence_i),
    .instr_rd(instr_rd), .instr_valid(instr_valid), .instr_error(instr_error),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_rlast(mem_rlast), .mem_rerror(mem_rerror)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [63:0] pc);
    pc_rd = pc;
    instr_read = 1;
  endtask
  task automatic hit(input logic [63:0] pc, input logic [31:0] exp);
    fetch(pc);
    @(negedge clk);
    check("hit_valid", instr_valid, 1);
    check("hit_error", instr_error, 0);
    check("hit_rd", instr_rd, exp);
    check("hit_no_req", mem_req, 0);
    step;
  endtask
  task automatic fault_chk(input logic [63:0] pc);
    fetch(pc);
    @(negedge clk);
    check("fault_valid", instr_valid, 1);
    check("fault_error", instr_error, 1);
    check("fault_rd", instr_rd, 0);
    check("fault_no_req", mem_req, 0);
    step;
    @(negedge clk);
    check("fault_no_req_next", mem_req, 0);
    step;
  endtask
  task automatic refill(input logic [31:0] addr, input logic [63:0] b0, input logic [63:0] b1,
                        input int wait_n, input logic e0, input logic fen);
    @(negedge clk);
    check("miss_valid", instr_valid, 0);
    check("miss_no_req", mem_req, 0);
    step;
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      check("wait_req", mem_req, 1);
      check("wait_addr", mem_addr, addr);
      step;
    end
    mem_ready = 1;
    @(negedge clk);
    check("req", mem_req, 1);
    check("req_addr", mem_addr, addr);
    check("req_valid", instr_valid, 0);
    step;
    mem_ready = 0;
    check("req_drop", mem_req, 0);
    mem_rvalid = 1;
    mem_rdata = b0;
    mem_rerror = e0;
    fence_i = fen;
    step;
    fence_i = 0;
    mem_rerror = 0;
    mem_rdata = b1;
    mem_rlast = 1;
    @(negedge clk);
    check("fill_valid", instr_valid, 0);
    step;
    mem_rvalid = 0;
    mem_rlast = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_error", instr_error, 0);
    check("rst_rd", instr_rd, 0);
    step;
    rst = 1;
    fetch(64'h8000_0000);
    refill(32'h8000_0000, B0, B1, 0, 0, 0);
    hit(64'h8000_0000, 32'h00000013);
    hit(64'h8000_0004, 32'h00100093);
    hit(64'h8000_000C, 32'h00000073);
    hit(64'h8000_0008, 32'h00208133);
    fetch(64'h8000_0400);
    refill(32'h8000_0400, C0, C1, 0, 0, 0);
    hit(64'h8000_0400, 32'h11111111);
    hit(64'h8000_040C, 32'h44444444);
    fetch(64'h8000_0000);
    refill(32'h8000_0000, B0, B1, 0, 0, 0);
    hit(64'h8000_0004, 32'h00100093);
    fetch(64'h8000_0010);
    refill(32'h8000_0010, C0, C1, 0, 1, 0);
    @(negedge clk);
    check("err_valid", instr_valid, 1);
    check("err_error", instr_error, 1);
    check("err_rd", instr_rd, 0);
    step;
    refill(32'h8000_0010, C0, C1, 0, 0, 0);
    hit(64'h8000_0014, 32'h22222222);
    fault_chk(64'h8000_0002);
    fault_chk(64'h1_0000_0000);
    fetch(64'h8000_0020);
    refill(32'h8000_0020, B0, B1, 0, 0, 1);
    refill(32'h8000_0020, B0, B1, 0, 0, 0);
    hit(64'h8000_0028, 32'h00208133);
    fetch(64'h8000_0020);
    fence_i = 1;
    @(negedge clk);
    check("fence_same_cycle_valid", instr_valid, 1);
    check("fence_same_cycle_rd", instr_rd, 32'h00000013);
    step;
    fence_i = 0;
    refill(32'h8000_0020, B0, B1, 0, 0, 0);
    hit(64'h8000_0020, 32'h00000013);
    fetch(64'h8000_0040);
    refill(32'h8000_0040, C0, C1, 5, 0, 0);
    hit(64'h8000_0048, 32'h33333333);
    fetch(64'h8000_0030);
    step;
    mem_ready = 1;
    step;
    mem_ready = 0;
    mem_rvalid = 1;
    mem_rdata = C0;
    step;
    mem_rvalid = 0;
    rst = 0;
    #1;
    check("rst_fill_req", mem_req, 0);
    check("rst_fill_valid", instr_valid, 0);
    check("rst_fill_addr", mem_addr, 0);
    step;
    rst = 1;
    fetch(64'h8000_0040);
    refill(32'h8000_0040, C0, C1, 0, 0, 0);
    hit(64'h8000_0044, 32'h22222222);
    instr_read = 0;
    @(negedge clk);
    check("idle_no_read_valid", instr_valid, 0);
    check("idle_no_read_rd", instr_rd, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
